// File: rtl/bcd_display_ctrl_if.sv
// Conversion request, result and display signals of bcd_display_ctrl.
// master: the side that requests conversions and watches the display.
// slave:  the controller itself.
interface bcd_display_ctrl_if;
  logic       load;
  logic [7:0] value;
  logic       busy;
  logic       done;
  logic       sign;
  logic [3:0] bcd_h;
  logic [3:0] bcd_t;
  logic [3:0] bcd_o;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output load, value,
    input  busy, done, sign, bcd_h, bcd_t, bcd_o, an, seg
  );

  modport slave (
    input  load, value,
    output busy, done, sign, bcd_h, bcd_t, bcd_o, an, seg
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Signed 8-bit to BCD converter (double-dabble, one step per clock) driving a
// 4-digit common-anode seven-segment display with leading-zero blanking.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for load; result registers hold the last conversion
// CONV  | one add-3/shift step per cycle, 8 steps, then publish result
module bcd_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic              clk,
  input logic              rst,
  bcd_display_ctrl_if.slave bus
);

  localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_MINUS = 7'b0111111;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        start, last;
  logic        sign_n_q;
  logic [7:0]  mag_in;
  logic [19:0] work_q, work_adj, work_next;   // {bcd[11:0], mag[7:0]}
  logic [2:0]  iter_q;

  logic        done_q, sign_q;
  logic [3:0]  bcd_h_q, bcd_t_q, bcd_o_q;

  logic [19:0] scan_cnt_q;
  logic [1:0]  idx_q;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start on load in IDLE, finish after the 8th step.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (bus.load) begin
        start   = 1'b1;
        state_d = CONV;
      end
      CONV: if (iter_q == 3'd7) begin
        last    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Magnitude of the operand; -128 wraps to 8'h80 = 128 as intended.
  assign mag_in = bus.value[7] ? (~bus.value + 8'd1) : bus.value;

  // Add-3 correction on every BCD nibble that is 5 or more.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[8 + 4*i +: 4] >= 4'd5)
        work_adj[8 + 4*i +: 4] = work_q[8 + 4*i +: 4] + 4'd3;
    end
  end

  assign work_next = work_adj << 1;

  // Conversion shift register and iteration count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q   <= '0;
      sign_n_q <= 1'b0;
      iter_q   <= '0;
    end else if (start) begin
      work_q   <= {12'd0, mag_in};
      sign_n_q <= bus.value[7];
      iter_q   <= '0;
    end else if (state_q == CONV) begin
      work_q   <= work_next;
      iter_q   <= iter_q + 3'd1;
    end
  end

  // Result registers update only when a conversion completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      bcd_h_q <= '0;
      bcd_t_q <= '0;
      bcd_o_q <= '0;
    end else begin
      done_q <= last;
      if (last) begin
        sign_q  <= sign_n_q;
        bcd_h_q <= work_next[19:16];
        bcd_t_q <= work_next[15:12];
        bcd_o_q <= work_next[11:8];
      end
    end
  end

  // Free-running digit scan, independent of conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 20'd1;
    end
  end

  // Digit select and glyph with leading-zero blanking.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    an_d[idx_q] = 1'b0;
    case (idx_q)
      2'd0: seg_d = glyph(bcd_o_q);
      2'd1: seg_d = (bcd_h_q == 4'd0 && bcd_t_q == 4'd0) ? SEG_BLANK : glyph(bcd_t_q);
      2'd2: seg_d = (bcd_h_q == 4'd0) ? SEG_BLANK : glyph(bcd_h_q);
      2'd3: seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  // Registered display drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.busy  = (state_q == CONV);
  assign bus.done  = done_q;
  assign bus.sign  = sign_q;
  assign bus.bcd_h = bcd_h_q;
  assign bus.bcd_t = bcd_t_q;
  assign bus.bcd_o = bcd_o_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: reference results from integer division of the
// signed operand, display expectations from the cycle count since reset.
module tb_bcd_display_ctrl;

  localparam int unsigned SCAN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_display_ctrl_if bus();

  bcd_display_ctrl #(.SCAN_DIV(SCAN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  logic m_sign = 1'b0;
  int   m_h = 0, m_t = 0, m_o = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [7:0] v);
    int s, mag;
    s      = int'($signed(v));
    mag    = (s < 0) ? -s : s;
    m_sign = (s < 0);
    m_h    = mag / 100;
    m_t    = (mag / 10) % 10;
    m_o    = mag % 10;
  endtask

  function automatic logic [6:0] exp_seg(input int idx);
    case (idx)
      0:       return glyph_tab[m_o];
      1:       return (m_h == 0 && m_t == 0) ? 7'b1111111 : glyph_tab[m_t];
      2:       return (m_h == 0) ? 7'b1111111 : glyph_tab[m_h];
      default: return m_sign ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  task automatic check_display(input int n);
    int idx;
    logic [3:0] a;
    repeat (n) begin
      tick();
      idx = int'(((cyc - 1) / SCAN) % 4);
      a   = 4'b1111;
      a[idx] = 1'b0;
      check("an", bus.an, a);
      check("seg", bus.seg, exp_seg(idx));
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_sign"}, bus.sign, m_sign);
    check({tag, "_h"}, bus.bcd_h, m_h);
    check({tag, "_t"}, bus.bcd_t, m_t);
    check({tag, "_o"}, bus.bcd_o, m_o);
  endtask

  // Starts in the cycle the load is presented, ends in the done cycle.
  task automatic do_conv(input logic [7:0] v);
    int busy_cyc = 0;
    int early_done = 0;
    bus.load  = 1'b1;
    bus.value = v;
    tick();
    bus.load  = 1'b0;
    bus.value = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      busy_cyc   += int'(bus.busy);
      early_done += int'(bus.done);
    end
    tick();
    model(v);
    check("busy_cycles", busy_cyc, 8);
    check("done_early", early_done, 0);
    check("done", bus.done, 1'b1);
    check("busy_at_done", bus.busy, 1'b0);
    check_result("res");
  endtask

  initial begin
    logic [7:0] vals [256];
    int first_done, done_cnt, stray;

    bus.load  = 1'b0;
    bus.value = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_an", bus.an, 4'b1111);
    check("rst_seg", bus.seg, 7'b1111111);
    check_result("rst");
    @(negedge clk);
    rst = 1'b0;

    // idle scan after reset: ones shows 0, others blank
    check_display(16);

    do_conv(8'h7F);
    check_display(16);
    do_conv(8'h80);
    check_display(16);
    do_conv(8'hFF);
    check_display(16);

    // second load at N+3 must be ignored
    first_done = -1;
    done_cnt   = 0;
    bus.load = 1'b1; bus.value = 8'h05;
    tick();
    bus.load = 1'b0; bus.value = 8'h00;
    tick();
    tick();
    bus.load = 1'b1; bus.value = 8'h63;
    tick();
    bus.load = 1'b0;
    for (int k = 5; k <= 14; k++) begin
      tick();
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
    end
    model(8'h05);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_done_cyc", first_done, 9);
    check("ign_busy", bus.busy, 1'b0);
    check_result("ign");

    // full-range sweep in random order, mostly back-to-back
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] tmp;
      j = $urandom_range(i, 0);
      tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      do_conv(vals[i]);
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) begin
          tick();
          check("gap_done", bus.done, 1'b0);
        end
      end
    end
    check_display(16);

    // reset in the middle of a conversion
    do_conv(8'h9C);
    bus.load = 1'b1; bus.value = 8'h7F;
    tick();
    bus.load = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_busy", bus.busy, 1'b0);
    check("mid_done", bus.done, 1'b0);
    check("mid_an", bus.an, 4'b1111);
    check("mid_seg", bus.seg, 7'b1111111);
    model(8'h00);
    check_result("mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      tick();
      stray += int'(bus.done) + int'(bus.busy);
    end
    check("mid_no_done", stray, 0);
    check_result("mid_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
# bcd_display_ctrl

Sequential controller that owns the binary-to-BCD conversion path and the 4-digit seven-segment display of the CPU board. It accepts an 8-bit two's-complement value on a load strobe and converts it with one add-3/shift step per clock (double-dabble, 8 iterations). It holds the last completed result and time-multiplexes it onto a common-anode display: sign, hundreds, tens and ones, with leading-zero blanking.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit; legal range 2 to 2^20-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  start conversion of value; sampled only when not busy.
- value  input  8  two's-complement operand.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when new result registers are valid.
- sign  output  1  result sign (1 = negative).
- bcd_h  output  4  result hundreds digit.
- bcd_t  output  4  result tens digit.
- bcd_o  output  4  result ones digit.
- an  output  4  digit enables, active-low. an[0] is ones, an[1] tens, an[2] hundreds, an[3] sign.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- States: IDLE and CONV.
- IDLE with load=1:
  - latch sign_n = value[7] and mag = value[7] ? (~value + 1) : value (8-bit; -128 gives 128).
  - clear the 12-bit BCD accumulator, set iter = 0, go to CONV.
- CONV, each cycle:
  - add 3 to every BCD nibble that is 5 or more.
  - shift {bcd, mag} left 1.
  - increment iter.
- After the 8th iteration:
  - load sign, bcd_h, bcd_t and bcd_o from the accumulator and sign_n.
  - pulse done and return to IDLE.
- load while in CONV is ignored and never queued. value is not sampled after the load edge.
- A load on the cycle done is high is sampled, because the state is already IDLE.
- Result registers change only at completion and hold between conversions.
- Scan:
  - a 20-bit counter counts 0 to SCAN_DIV-1.
  - on wrap, the 2-bit digit index increments 0→1→2→3→0.
  - scanning runs continuously and independently of conversion.
- Digit index 0 (ones): always shows its digit.
- Digit index 1 (tens): blank if bcd_h == 0 and bcd_t == 0.
- Digit index 2 (hundreds): blank if bcd_h == 0.
- Digit index 3 (sign): minus 0111111 if sign, else blank.
- Digit glyphs 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Blank glyph: 1111111.
- an and seg are registered from the current index and the result registers.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0.
  - sign 0, bcd_h/t/o 0, iter 0, scan counter 0, index 0.
  - an 1111, seg 1111111.
- Load edge at cycle N:
  - busy = 1 from cycle N+1 through N+8.
  - done = 1 and new results visible in cycle N+9, with busy = 0.
  - fastest back-to-back load is cycle N+9, so throughput is one conversion per 9 cycles.
- Display:
  - first edge after reset release gives an = 1110, seg = glyph of bcd_o (0 → 1000000).
  - each digit is held exactly SCAN_DIV cycles.
  - a new result appears on the currently lit digit on the cycle after done.
- Reset asserted mid-CONV: conversion aborts immediately, no done pulse, all outputs return to reset values asynchronously.

## Test plan
- Reset, then SCAN_DIV=4, idle:
  - an sequence 1110, 1101, 1011, 0111, each held 4 cycles.
  - seg shows 1000000 on ones and 1111111 on the other three digits.
- load with value=0x7F: busy for cycles N+1..N+8, done at N+9, sign=0, digits 1/2/7, no digit blanked.
- value=0x80: sign=1, digits 1/2/8, sign digit seg = 0111111.
- value=0xFF: sign=1, digits 0/0/1.
  - hundreds and tens blank, ones = 1111001.
  - sign digit shows minus.
- load=0x05 followed by load=0x63 at N+3: second load ignored, result 0/0/5, single done pulse.
- Full-range sweep: all 256 values, each compared against the integer-divided magnitude.
  - Also load at N+9 (the done cycle) and check it starts a new conversion.
  - Reset at N+4 mid-conversion: busy drops with no done pulse, and outputs return to their reset values.
